// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter that shares one enable-gated storage register among N_REQ writers.
// Each grant runs IDLE -> WRITE (reg_en pulse) -> ACK (one-hot ack pulse), one write per 3 cycles.
module register_write_arbiter #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*DATA_W-1:0]    req_data,
    output logic [DATA_W-1:0]          reg_data,
    output logic                       reg_en,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy,
    output logic [7:0]                 wr_count
);

    localparam int unsigned ID_W = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ACK_LSB = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   ptr;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [ID_W-1:0]   idx;
    logic [DATA_W-1:0] win_data;

    // First set request at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = ID_W'((32'(ptr) + i) % N_REQ);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
        win_data = req_data[32'(win_id) * DATA_W +: DATA_W];
    end

    // Sequencer: all outputs registered; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            reg_data <= '0;
            reg_en   <= 1'b0;
            ack      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            wr_count <= 8'd0;
        end else begin
            reg_en <= 1'b0;
            ack    <= '0;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state    <= WRITE;
                        grant_id <= win_id;
                        reg_data <= win_data;
                        reg_en   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= ACK;
                    ack   <= ACK_LSB << grant_id;
                end
                ACK: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    wr_count <= wr_count + 8'd1;
                    ptr      <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed bench for register_write_arbiter: scoreboard of expected grants plus a model of the
// downstream enable-gated register.
module tb_register_write_arbiter;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned ID_W   = 2;

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic                    clock   = 1'b0;
    logic                    reset_n = 1'b0;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]       reg_data;
    logic                    reg_en;
    logic [N_REQ-1:0]        ack;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;
    logic [7:0]              wr_count;

    logic [DATA_W-1:0] data_out = '0;
    exp_t              exp_q[$];
    logic              pend = 1'b0;
    logic [ID_W-1:0]   pend_id = '0;
    logic              auto_drop = 1'b0;
    logic              spacing_on = 1'b0;
    int                cyc = 0;
    int                last_grant = -1;
    int                n_tests = 0;
    int                n_fail = 0;

    register_write_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .req      (req),
        .req_data (req_data),
        .reg_data (reg_data),
        .reg_en   (reg_en),
        .ack      (ack),
        .grant_id (grant_id),
        .busy     (busy),
        .wr_count (wr_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc++;

    // Downstream register: captures Data_in while en is high.
    always @(posedge clock) if (reg_en === 1'b1) data_out <= reg_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_grant(input int id, input logic [DATA_W-1:0] d);
        exp_t e;
        e.id   = ID_W'(id);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic set_data(input int k, input logic [DATA_W-1:0] d);
        req_data[k*DATA_W +: DATA_W] = d;
    endtask

    // One cycle; requesters in auto-drop mode release req while seeing their ack.
    task automatic tick();
        @(negedge clock);
        if (auto_drop) req = req & ~ack;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((exp_q.size() != 0 || pend || busy) && n < 100);
        check(tag, {31'b0, exp_q.size() == 0 && !pend && !busy}, 32'd1);
    endtask

    always @(negedge reset_n) pend = 1'b0;

    // Scoreboard monitor: grants popped on reg_en, ack checked in the following cycle.
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            pend       = 1'b0;
            last_grant = -1;
        end else begin
            check("en_ack_exclusive", {31'b0, reg_en && (ack != '0)}, 32'd0);
            check("ack_onehot", {31'b0, $countones(ack) <= 1}, 32'd1);
            if (pend) begin
                check("ack_pulse", 32'(ack), 32'(4'b0001 << pend_id));
                pend = 1'b0;
            end else begin
                check("ack_quiet", 32'(ack), 32'd0);
            end
            if (!spacing_on) last_grant = -1;
            if (reg_en) begin
                check("grant_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("grant_id", 32'(grant_id), 32'(e.id));
                    check("reg_data", 32'(reg_data), 32'(e.data));
                    pend    = 1'b1;
                    pend_id = e.id;
                    if (spacing_on && last_grant >= 0) check("grant_spacing", 32'(cyc - last_grant), 32'd3);
                    last_grant = cyc;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_reg_en"}, {31'b0, reg_en}, 32'd0);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_reg_data"}, 32'(reg_data), 32'd0);
        check({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_wr_count"}, 32'(wr_count), 32'd0);
    endtask

    initial begin
        logic [N_REQ-1:0]  rnd;
        logic [DATA_W-1:0] rnd_d[N_REQ];
        int                rnd_id;
        int                n;

        req      = '0;
        req_data = '0;
        repeat (2) tick();
        check_all_zero("reset");

        // Random request, then reset asserted mid-cycle during ACK.
        reset_n = 1'b1;
        rnd     = 4'($urandom_range(1, 15));
        rnd_id  = -1;
        for (int k = 0; k < int'(N_REQ); k++) begin
            rnd_d[k] = 8'($urandom_range(0, 255));
            set_data(k, rnd_d[k]);
            if (rnd_id < 0 && rnd[k]) rnd_id = k;
        end
        expect_grant(rnd_id, rnd_d[rnd_id]);
        req = rnd;
        tick();
        check("rnd_reg_en", {31'b0, reg_en}, 32'd1);
        tick();
        check("rnd_ack", 32'(ack), 32'(4'b0001 << rnd_id));
        #2 reset_n = 1'b0;
        #1 check_all_zero("midcycle_reset");
        req = '0;
        tick();
        reset_n = 1'b1;
        repeat (3) begin
            tick();
            check("idle_busy", {31'b0, busy}, 32'd0);
        end

        // Single write from requester 1 with exact latency.
        auto_drop = 1'b1;
        set_data(1, 8'h18);
        expect_grant(1, 8'h18);
        req = 4'b0010;
        tick();
        check("single_reg_en", {31'b0, reg_en}, 32'd1);
        check("single_busy_write", {31'b0, busy}, 32'd1);
        tick();
        check("single_ack", 32'(ack), 32'h2);
        check("single_reg_en_low", {31'b0, reg_en}, 32'd0);
        tick();
        check("single_wr_count", 32'(wr_count), 32'd1);
        check("single_busy_idle", {31'b0, busy}, 32'd0);
        check("single_data_out", 32'(data_out), 32'h18);

        // Full contention from reset: grants 0,1,2,3 at 3-cycle spacing.
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        set_data(0, 8'h11); set_data(1, 8'h22); set_data(2, 8'h33); set_data(3, 8'h44);
        for (int k = 0; k < 4; k++) expect_grant(k, 8'(8'h11 * (k + 1)));
        spacing_on = 1'b1;
        req = 4'b1111;
        wait_done("contention_done");
        spacing_on = 1'b0;
        check("contention_data_out", 32'(data_out), 32'h44);
        check("contention_wr_count", 32'(wr_count), 32'd4);

        // Fairness: requesters 0 and 2 held high, grants must alternate.
        auto_drop = 1'b0;
        set_data(0, 8'h81);
        set_data(2, 8'h18);
        for (int k = 0; k < 3; k++) begin
            expect_grant(0, 8'h81);
            expect_grant(2, 8'h18);
        end
        spacing_on = 1'b1;
        req = 4'b0101;
        n = 0;
        do begin
            tick();
            n++;
        end while (exp_q.size() != 0 && n < 100);
        req = '0;
        wait_done("fairness_done");
        spacing_on = 1'b0;
        check("fairness_wr_count", 32'(wr_count), 32'd10);

        // Withdrawal during WRITE: ack and write still complete.
        auto_drop = 1'b1;
        set_data(3, 8'h5A);
        expect_grant(3, 8'h5A);
        req = 4'b1000;
        tick();
        check("withdraw_reg_en", {31'b0, reg_en}, 32'd1);
        req = '0;
        wait_done("withdraw_done");
        check("withdraw_data_out", 32'(data_out), 32'h5A);
        check("withdraw_wr_count", 32'(wr_count), 32'd11);

        // Move the pointer to 2 before the abort test.
        set_data(1, 8'h3C);
        expect_grant(1, 8'h3C);
        req = 4'b0010;
        wait_done("ptr_setup_done");
        check("ptr_setup_wr_count", 32'(wr_count), 32'd12);

        // Reset pulse during WRITE aborts the write; pointer restarts at 0.
        set_data(3, 8'hA5);
        expect_grant(3, 8'hA5);
        req = 4'b1000;
        tick();
        check("abort_reg_en", {31'b0, reg_en}, 32'd1);
        check("abort_grant_id", 32'(grant_id), 32'd3);
        #2 reset_n = 1'b0;
        #1 check_all_zero("abort");
        set_data(1, 8'h96);
        expect_grant(1, 8'h96);
        expect_grant(3, 8'hA5);
        req = 4'b1010;
        tick();
        check("abort_write_lost", 32'(data_out), 32'h3C);
        reset_n = 1'b1;
        wait_done("after_abort_done");
        check("after_abort_data_out", 32'(data_out), 32'hA5);
        check("after_abort_wr_count", 32'(wr_count), 32'd2);

        // Counter wrap: 256 back-to-back writes from requester 0.
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        auto_drop = 1'b0;
        set_data(0, 8'hC3);
        for (int i = 0; i < 256; i++) expect_grant(0, 8'hC3);
        spacing_on = 1'b1;
        req = 4'b0001;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (ack == '0 && n < 10);
            if (i == 255) req = '0;
            tick();
            check("wrap_wr_count", 32'(wr_count), 32'((i + 1) % 256));
        end
        spacing_on = 1'b0;
        wait_done("wrap_done");
        check("wrap_final_zero", 32'(wr_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Round-robin arbiter and sequencer that shares one 8-bit storage register among `N_REQ` independent writers. Each writer raises a request with its data. The block picks one winner, drives the register's data and enable for exactly one clock, then returns a one-cycle acknowledge to the winner. It sits directly in front of the 8-bit enable-gated register (`Data_in`/`en`/`Data_out`) and is the only block allowed to drive that register's inputs.

## Interface

- `N_REQ`, default 4, number of requesters (2..8).
- `DATA_W`, default 8, data width; must match the register width.
- `clock`  input  1  rising-edge system clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `req`  input  N_REQ  per-requester write request, level.
- `req_data`  input  N_REQ*DATA_W  packed write data; requester k occupies bits [k*DATA_W +: DATA_W].
- `reg_data`  output  DATA_W  to register `Data_in`.
- `reg_en`  output  1  to register `en`.
- `ack`  output  N_REQ  one-hot, one-cycle acknowledge to the winner.
- `grant_id`  output  clog2(N_REQ)  index of the current or last winner.
- `busy`  output  1  high while in WRITE or ACK.
- `wr_count`  output  8  count of completed writes, wraps.

## Operation

- FSM has three states: IDLE, WRITE, ACK. All outputs are registered.
- IDLE:
  - If any `req` bit is high, select a winner by round-robin.
  - Latch `grant_id` and that requester's `req_data` slice into `reg_data`.
  - Go to WRITE.
  - If no request is present, stay in IDLE.
- WRITE:
  - `reg_en`=1 for exactly this cycle.
  - The register captures `reg_data` on the edge that ends WRITE.
  - Go to ACK.
- ACK:
  - `ack[grant_id]`=1 for exactly this cycle.
  - `wr_count` increments by 1 (modulo 256) on the edge that ends ACK.
  - Update the priority pointer: `ptr` ← (`grant_id`+1) mod N_REQ.
  - Go to IDLE.
- Round-robin search:
  - Order is `ptr`, `ptr`+1, …, wrapping modulo N_REQ; the first set `req` bit wins.
  - `ptr` resets to 0.
- Data is sampled only at the grant edge. Later changes to `req_data` do not affect the write in progress.
- Request withdrawn after grant (`req[k]` falls during WRITE or ACK): the write still completes and `ack[k]` is still issued.
- Requester obligations:
  - Hold `req` and data stable until granted.
  - Drop `req` on the edge after seeing `ack`.
- A `req` still high in the IDLE cycle after ACK is treated as a new request, at lowest priority.
- New requests during WRITE or ACK are ignored until the next IDLE.
- `busy` = (state ≠ IDLE).
- `reg_en` and `ack` are never high in the same cycle.
- At most one `ack` bit is high in any cycle.

## Timing

- Reset (async, `reset_n`=0) forces, immediately and without waiting for a clock edge:
  - state=IDLE, `ptr`=0;
  - `reg_en`=0, `ack`=0, `reg_data`=0, `grant_id`=0, `busy`=0, `wr_count`=0.
- Reset mid-transaction aborts it:
  - no `ack` is issued;
  - any write not yet captured is lost;
  - `wr_count` does not increment.
- Release of reset is synchronous to `clock`. The first arbitration happens on the first rising edge with `reset_n`=1.
- Latency: request high before edge E0 gives grant at E0, `reg_en` high in cycle E0→E1, and register updated at E1.
- `ack` is high in cycle E1→E2, and `wr_count` updates at E2.
- Throughput: one write per 3 cycles under continuous contention (IDLE→WRITE→ACK).
- `wr_count` wraps from 255 to 0 with no flag.

## Test plan

- **Reset:** assert `reset_n`=0 mid-cycle with random `req` → all outputs 0 immediately; after release with `req`=0, `busy` stays 0.
- **Single write:** `req[1]`=1 with data 0x18 → one cycle later `reg_en`=1, `reg_data`=0x18, `grant_id`=1; next cycle `ack`=4'b0010; `wr_count`=1; register `Data_out`=0x18.
- **Full contention from reset:** `req`=4'b1111 with data 0x11/0x22/0x33/0x44; each requester drops `req` after its ack → grants in order 0,1,2,3 at 3-cycle spacing; `Data_out` ends at 0x44; `wr_count`=4.
- **Fairness:** `req[0]` and `req[2]` held high permanently with data 0x81 and 0x18 → grants alternate 0,2,0,2; `reg_data` alternates 0x81/0x18; no requester is granted twice in a row.
- **Withdrawal and reset abort:**
  - Drop `req[3]` during WRITE → `ack[3]` still pulses and the write lands.
  - Separately, pulse `reset_n` low during WRITE → `reg_en` falls at once, no ack, `wr_count` unchanged at 0, next grant searches from `ptr`=0.
- **Counter wrap:** 256 back-to-back single-requester writes → `wr_count` reads 255 after the 255th ack, then 0 after the 256th.
